signed_tick_counter: RTL and testbench

Parametrised signed up/down counter with programmable prescaler, synchronous load, wrap or saturate overflow modes, and registered sign-magnitude outputs driving a multi-digit seven-segment display. It sits between the board clock and the HEX displays as the general-purpose timed count source for lab top-levels. It replaces single-width, up-only counters whose displayed magnitude lagged the count by one cycle.

---
 rtl/signed_tick_counter_pkg.sv | 10 +
 rtl/seg_defs.vh | 8 +
 rtl/signed_tick_counter_hex7seg.sv | 11 +
 rtl/signed_tick_counter.sv | 124 ++++++++++++
 tb/tb_signed_tick_counter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/signed_tick_counter_pkg.sv
// Shared segment constants and the nibble-to-segment helper.
package signed_tick_counter_pkg;

  `include "seg_defs.vh"

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_DIGITS[nibble];
  endfunction

endpackage

// File: rtl/seg_defs.vh
// Active-low seven-segment patterns, bit 6 = g ... bit 0 = a.
localparam logic [6:0] SEG_BLANK = 7'h7F;
localparam logic [6:0] SEG_MINUS = 7'h3F;
// Digit patterns 0-F, index 0 in the least significant slot.
localparam logic [15:0][6:0] SEG_DIGITS = {
  7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
  7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
};

// File: rtl/signed_tick_counter_hex7seg.sv
// Single hex digit to active-low seven-segment decoder.
module signed_tick_counter_hex7seg
  import signed_tick_counter_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/signed_tick_counter.sv
// Signed up/down counter with prescaler, load, wrap/saturate and
// zero-lag registered sign-magnitude seven-segment outputs.
module signed_tick_counter
  import signed_tick_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 10000000,
  parameter int unsigned DIGITS   = WIDTH / 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  saturate,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic [WIDTH-1:0]      magnitude,
  output logic                  negative,
  output logic                  tick,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex_seg,
  output logic [6:0]            sign_seg
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PreLast = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0]    CntMax  = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0]    CntMin  = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [7*DIGITS-1:0] HexZero = {DIGITS{SEG_DIGITS[0]}};

  logic [PW-1:0]       pre_q, pre_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    magnitude_q, magnitude_d;
  logic                negative_q, negative_d;
  logic                tick_q, tick_d;
  logic                overflow_q, overflow_d;
  logic [7*DIGITS-1:0] hex_seg_q, hex_seg_d;
  logic [6:0]          sign_seg_q, sign_seg_d;

  always_comb begin
    pre_d      = pre_q;
    count_d    = count_q;
    tick_d     = 1'b0;
    overflow_d = 1'b0;
    if (load) begin
      count_d = load_value;
      pre_d   = '0;
    end else if (enable) begin
      if (pre_q == PreLast) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (up_down) begin
          if (count_q == CntMax) begin
            overflow_d = 1'b1;
            count_d    = saturate ? CntMax : CntMin;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == CntMin) begin
            overflow_d = 1'b1;
            count_d    = saturate ? CntMin : CntMax;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Display terms come from count_d so they land on the same edge as count.
  always_comb begin
    negative_d  = count_d[WIDTH-1];
    magnitude_d = negative_d ? (~count_d + 1'b1) : count_d;
    sign_seg_d  = negative_d ? SEG_MINUS : SEG_BLANK;
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] nibble;
    if (4 * i + 4 <= WIDTH) begin : g_in_range
      assign nibble = magnitude_d[4*i +: 4];
    end else begin : g_out_of_range
      assign nibble = 4'h0;
    end
    signed_tick_counter_hex7seg u_hex7seg (
      .nibble_i (nibble),
      .seg_o    (hex_seg_d[7*i +: 7])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q       <= '0;
      count_q     <= '0;
      magnitude_q <= '0;
      negative_q  <= 1'b0;
      tick_q      <= 1'b0;
      overflow_q  <= 1'b0;
      hex_seg_q   <= HexZero;
      sign_seg_q  <= SEG_BLANK;
    end else begin
      pre_q       <= pre_d;
      count_q     <= count_d;
      magnitude_q <= magnitude_d;
      negative_q  <= negative_d;
      tick_q      <= tick_d;
      overflow_q  <= overflow_d;
      hex_seg_q   <= hex_seg_d;
      sign_seg_q  <= sign_seg_d;
    end
  end

  assign count     = count_q;
  assign magnitude = magnitude_q;
  assign negative  = negative_q;
  assign tick      = tick_q;
  assign overflow  = overflow_q;
  assign hex_seg   = hex_seg_q;
  assign sign_seg  = sign_seg_q;

endmodule

// File: tb/tb_signed_tick_counter.sv
// Directed bench for signed_tick_counter at WIDTH=8, PRESCALE=4.
module tb_signed_tick_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        up_down = 1'b0;
  logic        saturate = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  load_value = 8'h00;
  logic [7:0]  count;
  logic [7:0]  magnitude;
  logic        negative;
  logic        tick;
  logic        overflow;
  logic [13:0] hex_seg;
  logic [6:0]  sign_seg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  signed_tick_counter #(
    .WIDTH    (8),
    .PRESCALE (4),
    .DIGITS   (2)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .enable     (enable),
    .up_down    (up_down),
    .saturate   (saturate),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .magnitude  (magnitude),
    .negative   (negative),
    .tick       (tick),
    .overflow   (overflow),
    .hex_seg    (hex_seg),
    .sign_seg   (sign_seg)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    cycles(2);
    n_tests++;
    if ({count, magnitude, negative, tick, overflow} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%h mag=%h neg=%b tick=%b ovf=%b, want all zero",
               count, magnitude, negative, tick, overflow);
    end
    n_tests++;
    if (hex_seg !== 14'h2040) begin
      n_fail++;
      $display("FAIL reset_hex: got %h, want 2040", hex_seg);
    end
    n_tests++;
    if (sign_seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_sign: got %h, want 7f", sign_seg);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up;
    logic [7:0] exp_cnt;
    enable  = 1'b1;
    up_down = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycles(1);
      exp_cnt = 8'(k / 4);
      n_tests++;
      if ({count, magnitude, tick, overflow} !== {exp_cnt, exp_cnt, (k % 4 == 0), 1'b0}) begin
        n_fail++;
        $display("FAIL count_up[%0d]: got cnt=%h mag=%h tick=%b ovf=%b, want cnt=%h mag=%h tick=%b ovf=0",
                 k, count, magnitude, tick, overflow, exp_cnt, exp_cnt, (k % 4 == 0));
      end
    end
    n_tests++;
    if ({hex_seg, sign_seg, negative} !== {14'h2012, 7'h7F, 1'b0}) begin
      n_fail++;
      $display("FAIL count_up_display: got hex=%h sign=%h neg=%b, want hex=2012 sign=7f neg=0",
               hex_seg, sign_seg, negative);
    end
  endtask

  task automatic test_wrap;
    load = 1'b1; load_value = 8'h7F; saturate = 1'b0; up_down = 1'b1;
    cycles(1);
    load = 1'b0;
    n_tests++;
    if ({count, magnitude, tick} !== {8'h7F, 8'h7F, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_load: got cnt=%h mag=%h tick=%b, want 7f 7f 0", count, magnitude, tick);
    end
    cycles(3);
    n_tests++;
    if ({count, tick, overflow} !== {8'h7F, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_early: got cnt=%h tick=%b ovf=%b, want 7f 0 0", count, tick, overflow);
    end
    cycles(1);
    n_tests++;
    if ({count, magnitude, negative, tick, overflow} !== {8'h80, 8'h80, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_step: got cnt=%h mag=%h neg=%b tick=%b ovf=%b, want 80 80 1 1 1",
               count, magnitude, negative, tick, overflow);
    end
    n_tests++;
    if ({hex_seg, sign_seg} !== {14'h0040, 7'h3F}) begin
      n_fail++;
      $display("FAIL wrap_display: got hex=%h sign=%h, want hex=0040 sign=3f", hex_seg, sign_seg);
    end
    cycles(1);
    n_tests++;
    if ({tick, overflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL wrap_pulse_width: got tick=%b ovf=%b, want 0 0", tick, overflow);
    end
  endtask

  task automatic test_saturate;
    logic [7:0] exp_cnt [3];
    logic       exp_ovf [3];
    exp_cnt = '{8'h80, 8'h80, 8'h80};
    exp_ovf = '{1'b0, 1'b1, 1'b1};
    // Re-align: load restarts the prescaler.
    load = 1'b1; load_value = 8'h81; saturate = 1'b1; up_down = 1'b0;
    cycles(1);
    load = 1'b0;
    n_tests++;
    if (count !== 8'h81) begin
      n_fail++;
      $display("FAIL sat_load: got %h, want 81", count);
    end
    for (int s = 0; s < 3; s++) begin
      cycles(3);
      n_tests++;
      if (tick !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_gap[%0d]: got tick=%b, want 0", s, tick);
      end
      cycles(1);
      n_tests++;
      if ({count, magnitude, tick, overflow} !== {exp_cnt[s], 8'h80, 1'b1, exp_ovf[s]}) begin
        n_fail++;
        $display("FAIL sat_step[%0d]: got cnt=%h mag=%h tick=%b ovf=%b, want %h 80 1 %b",
                 s, count, magnitude, tick, overflow, exp_cnt[s], exp_ovf[s]);
      end
    end
  endtask

  task automatic test_load_conflict;
    saturate = 1'b0; up_down = 1'b1;
    cycles(3);
    load = 1'b1; load_value = 8'hF6;
    cycles(1);
    load = 1'b0;
    n_tests++;
    if ({count, magnitude, negative, tick, overflow} !== {8'hF6, 8'h0A, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL load_conflict: got cnt=%h mag=%h neg=%b tick=%b ovf=%b, want f6 0a 1 0 0",
               count, magnitude, negative, tick, overflow);
    end
    n_tests++;
    if (hex_seg !== 14'h2008) begin
      n_fail++;
      $display("FAIL load_conflict_hex: got %h, want 2008", hex_seg);
    end
    cycles(3);
    n_tests++;
    if ({count, tick} !== {8'hF6, 1'b0}) begin
      n_fail++;
      $display("FAIL load_next_early: got cnt=%h tick=%b, want f6 0", count, tick);
    end
    cycles(1);
    n_tests++;
    if ({count, magnitude, tick} !== {8'hF7, 8'h09, 1'b1}) begin
      n_fail++;
      $display("FAIL load_next_step: got cnt=%h mag=%h tick=%b, want f7 09 1", count, magnitude, tick);
    end
  endtask

  task automatic test_enable_pause;
    cycles(2);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      n_tests++;
      if ({count, tick} !== {8'hF7, 1'b0}) begin
        n_fail++;
        $display("FAIL pause[%0d]: got cnt=%h tick=%b, want f7 0", k, count, tick);
      end
    end
    enable = 1'b1;
    cycles(1);
    n_tests++;
    if ({count, tick} !== {8'hF7, 1'b0}) begin
      n_fail++;
      $display("FAIL resume_early: got cnt=%h tick=%b, want f7 0", count, tick);
    end
    cycles(1);
    n_tests++;
    if ({count, tick} !== {8'hF8, 1'b1}) begin
      n_fail++;
      $display("FAIL resume_step: got cnt=%h tick=%b, want f8 1", count, tick);
    end
  endtask

  task automatic test_mid_reset;
    load = 1'b1; load_value = 8'hFD;
    cycles(1);
    load = 1'b0;
    n_tests++;
    if ({count, magnitude} !== {8'hFD, 8'h03}) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got cnt=%h mag=%h, want fd 03", count, magnitude);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({count, magnitude, negative, tick, overflow, hex_seg, sign_seg}
        !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 14'h2040, 7'h7F}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got cnt=%h mag=%h neg=%b tick=%b ovf=%b hex=%h sign=%h",
               count, magnitude, negative, tick, overflow, hex_seg, sign_seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    n_tests++;
    if ({count, tick} !== {8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_early: got cnt=%h tick=%b, want 00 0", count, tick);
    end
    cycles(1);
    n_tests++;
    if ({count, tick} !== {8'h01, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_step: got cnt=%h tick=%b, want 01 1", count, tick);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_saturate();
    test_load_conflict();
    test_enable_pause();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
